// File: rtl/pix_pack_pkg.sv
// Shared types for the pixel packer: FSM state, word width, byte enables.
// be_from_bits maps a valid-bit count to top-aligned byte write enables.
package pix_pack_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Valid bits are MSB-aligned, so enables grow from web[3] down.
  function automatic logic [3:0] be_from_bits(
    input logic [5:0] vb
  );
    logic [2:0] nbytes;
    logic [3:0] be;
    nbytes = 3'((7'(vb) + 7'd7) >> 3);
    case (nbytes)
      3'd0:    be = 4'b0000;
      3'd1:    be = 4'b1000;
      3'd2:    be = 4'b1100;
      3'd3:    be = 4'b1110;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/pix_word_asm.sv
// Packs PIX_W-bit pixels MSB-first into 32-bit words.
// In: pix/pix_en/clr. Out: word (incl. current pixel), word_full, vbits.
module pix_word_asm
  import pix_pack_pkg::*;
#(
  parameter int PIX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PIX_W-1:0] pix,
  input  logic             pix_en,
  output logic [31:0]      word,
  output logic             word_full,
  output logic [5:0]       vbits
);

  localparam int NPIX = WORD_W / PIX_W;
  localparam logic [5:0] LAST = 6'(NPIX - 1);

  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic [5:0]  sh;

  // Outputs already include this cycle's pixel so the
  // caller can register a full or final word directly.
  always_comb begin
    sh = 6'(WORD_W - PIX_W)
       - 6'(32'(cnt_q) * 32'(PIX_W));
    word = sr_q | (32'(pix) << sh);
    word_full = pix_en && (cnt_q == LAST);
    vbits = 6'((32'(cnt_q) + 32'd1) * 32'(PIX_W));
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr || word_full) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (pix_en) begin
      cnt_d = cnt_q + 6'd1;
      sr_d  = word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/pix_pack_bram.sv
// Packs a frame of pixels into 32-bit words and writes them to BRAM port B.
// In: start/abort/h/w/pix/pix_en. Out: BRAM port B, busy/done/ovf.
module pix_pack_bram
  import pix_pack_pkg::*;
#(
  parameter int          PIX_W     = 1,
  parameter logic [31:0] BASE_ADDR = 32'h4300_0000,
  parameter int          DIM_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] h,
  input  logic [DIM_W-1:0] w,
  input  logic [PIX_W-1:0] pix,
  input  logic             pix_en,
  output logic             clkb,
  output logic             rstb,
  output logic             enb,
  output logic [3:0]       web,
  output logic [31:0]      addrb,
  output logic [31:0]      dinb,
  input  logic [31:0]      doutb,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int TW = 2 * DIM_W;

  state_e       state_q, state_d;
  logic [TW-1:0] tot_q, tot_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  din_q, din_d;
  logic [3:0]   web_q, web_d;
  logic         enb_q, enb_d;
  logic         done_q, done_d;
  logic         ovf_q, ovf_d;
  logic         rstb_q, rstb_d;

  logic [TW-1:0] prod;
  logic         start_ok;
  logic         acc;
  logic         last;
  logic         asm_clr;
  logic [31:0]  a_word;
  logic         a_full;
  logic [5:0]   a_vbits;

  logic         unused_doutb;
  assign unused_doutb = ^doutb;

  pix_word_asm #(
    .PIX_W (PIX_W)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .pix       (pix),
    .pix_en    (acc),
    .word      (a_word),
    .word_full (a_full),
    .vbits     (a_vbits)
  );

  always_comb begin
    prod = TW'(h) * TW'(w);
    start_ok = start && !abort
            && (state_q == ST_IDLE);
    acc = pix_en && !abort
       && (state_q == ST_RUN);
    last = acc && ((cnt_q + TW'(1)) == tot_q);
    // Partial word is dropped on abort, new frame
    // or once the final pixel has been handed out.
    asm_clr = abort || start_ok || last;

    state_d = state_q;
    tot_d   = tot_q;
    cnt_d   = cnt_q;
    addr_d  = enb_q ? addr_q + 32'd4 : addr_q;
    din_d   = din_q;
    web_d   = 4'b0000;
    enb_d   = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    rstb_d  = 1'b0;

    if (pix_en && (state_q == ST_FLUSH
        || (state_q == ST_IDLE && done_q)))
      ovf_d = 1'b1;

    if (abort) begin
      state_d = ST_IDLE;
      addr_d  = BASE_ADDR;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            ovf_d  = 1'b0;
            addr_d = BASE_ADDR;
            cnt_d  = '0;
            tot_d  = prod;
            if (prod == '0) done_d = 1'b1;
            else state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (acc) begin
            cnt_d = cnt_q + TW'(1);
            if (a_full || last) begin
              enb_d = 1'b1;
              web_d = be_from_bits(a_vbits);
              din_d = a_word;
            end
            if (last) state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tot_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      din_q   <= '0;
      web_q   <= '0;
      enb_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rstb_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      web_q   <= web_d;
      enb_q   <= enb_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      rstb_q  <= rstb_d;
    end
  end

  assign clkb  = clk;
  assign rstb  = rstb_q;
  assign enb   = enb_q;
  assign web   = web_q;
  assign addrb = addr_q;
  assign dinb  = din_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pix_pack_bram.sv
// Bench for pix_pack_bram: three widths (1, 8, 4 bits), table of frames,
// write scoreboard, plus abort and mid-word reset sequences.
module tb_pix_pack_bram;

  localparam logic [31:0] BASE = 32'h4300_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  web;
  } wr_t;

  typedef struct {
    int s, hh, ww, gap, kind, extra, nwr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_s, abort_s, pix_en_s;
  logic [10:0] h_s, w_s;
  logic [15:0] pix_s;
  logic [31:0] doutb_s;
  int          sel;

  logic        start_a[3], abort_a[3], pen_a[3];
  logic        clkb_a[3], rstb_a[3], enb_a[3];
  logic        busy_a[3], done_a[3], ovf_a[3];
  logic [3:0]  web_a[3];
  logic [31:0] addr_a[3], din_a[3];

  assign doutb_s = 32'h0;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      start_a[k] = start_s && (sel == k);
      abort_a[k] = abort_s && (sel == k);
      pen_a[k]   = pix_en_s && (sel == k);
    end
  end

  pix_pack_bram #(.PIX_W(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .start(start_a[0]), .abort(abort_a[0]),
    .h(h_s), .w(w_s),
    .pix(pix_s[0:0]), .pix_en(pen_a[0]),
    .clkb(clkb_a[0]), .rstb(rstb_a[0]),
    .enb(enb_a[0]), .web(web_a[0]),
    .addrb(addr_a[0]), .dinb(din_a[0]),
    .doutb(doutb_s), .busy(busy_a[0]),
    .done(done_a[0]), .ovf(ovf_a[0]));

  pix_pack_bram #(.PIX_W(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .start(start_a[1]), .abort(abort_a[1]),
    .h(h_s), .w(w_s),
    .pix(pix_s[7:0]), .pix_en(pen_a[1]),
    .clkb(clkb_a[1]), .rstb(rstb_a[1]),
    .enb(enb_a[1]), .web(web_a[1]),
    .addrb(addr_a[1]), .dinb(din_a[1]),
    .doutb(doutb_s), .busy(busy_a[1]),
    .done(done_a[1]), .ovf(ovf_a[1]));

  pix_pack_bram #(.PIX_W(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .start(start_a[2]), .abort(abort_a[2]),
    .h(h_s), .w(w_s),
    .pix(pix_s[3:0]), .pix_en(pen_a[2]),
    .clkb(clkb_a[2]), .rstb(rstb_a[2]),
    .enb(enb_a[2]), .web(web_a[2]),
    .addrb(addr_a[2]), .dinb(din_a[2]),
    .doutb(doutb_s), .busy(busy_a[2]),
    .done(done_a[2]), .ovf(ovf_a[2]));

  wr_t exp_q[$];
  wr_t got_q[$];
  int  n_tot = 0;
  int  n_bad = 0;
  int  done_cnt = 0;
  int  cnum = 0;
  int  wr_cyc = 0;
  int  done_cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  function automatic int pw_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 8 : 4;
  endfunction

  function automatic wr_t got_at(input int k);
    wr_t r;
    r = '{addr: '0, din: '0, web: '0};
    if (k < got_q.size()) r = got_q[k];
    return r;
  endfunction

  always @(negedge clk) begin
    wr_t g, e;
    cnum++;
    if (rst_n) begin
      if (done_a[sel]) begin
        done_cnt++;
        done_cyc = cnum;
      end
      if (enb_a[sel]) begin
        g = '{addr: addr_a[sel], din: din_a[sel],
              web: web_a[sel]};
        got_q.push_back(g);
        wr_cyc = cnum;
        if (exp_q.size() == 0) begin
          n_tot++;
          n_bad++;
          $display("FAIL stray_write: got %h/%h/%h want none",
                   g.addr, g.din, g.web);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", g.addr, e.addr);
          chk("wr_din", g.din, e.din);
          chk("wr_web", 32'(g.web), 32'(e.web));
        end
      end else begin
        chk("idle_web", 32'(web_a[sel]), 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int s, input int hh,
                           input int ww, input int gap,
                           input int kind, input int extra);
    int          pw, nb, d0;
    logic [31:0] acc, a;
    logic [15:0] v;
    logic [3:0]  m;
    wr_t         e;
    pw = pw_of(s);
    sel = s;
    exp_q.delete();
    got_q.delete();
    acc = '0;
    nb = 0;
    a = BASE;
    d0 = done_cnt;
    h_s = 11'(hh);
    w_s = 11'(ww);
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    for (int i = 0; i < hh * ww; i++) begin
      for (int g = 0; g < gap; g++) begin
        pix_en_s = 1'b0;
        cyc();
      end
      case (kind)
        0:       v = 16'((i % 2 == 0) ? 1 : 0);
        1:       v = 16'(i + 1);
        default: v = 16'($urandom);
      endcase
      v = v & 16'((1 << pw) - 1);
      acc |= 32'(v) << (32 - pw - nb);
      nb += pw;
      if (nb == 32) begin
        e = '{addr: a, din: acc, web: 4'hF};
        exp_q.push_back(e);
        a += 32'd4;
        acc = '0;
        nb = 0;
      end
      pix_s = v;
      pix_en_s = 1'b1;
      cyc();
    end
    pix_en_s = 1'b0;
    if (nb > 0) begin
      m = 4'hF << (4 - (nb + 7) / 8);
      e = '{addr: a, din: acc, web: m};
      exp_q.push_back(e);
    end
    for (int x = 0; x < extra; x++) begin
      pix_s = '1;
      pix_en_s = 1'b1;
      cyc();
    end
    pix_en_s = 1'b0;
    for (int t = 0; t < 40 && done_cnt == d0; t++)
      cyc();
    cyc();
    cyc();
    cyc();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("ovf", 32'(ovf_a[s]), 32'(extra > 0));
    chk("busy_end", 32'(busy_a[s]), 32'd0);
    if (got_q.size() > 0)
      chk("done_lag", 32'(done_cyc - wr_cyc), 32'd1);
  endtask

  vec_t tbl[9];

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    tbl[0] = '{0, 4, 8, 0, 0, 0, 1};
    tbl[1] = '{1, 1, 6, 0, 1, 0, 2};
    tbl[2] = '{2, 3, 5, 1, 2, 0, 2};
    tbl[3] = '{1, 1, 6, 0, 1, 3, 2};
    tbl[4] = '{0, 4, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 3, 7, 0, 2, 0, 6};
    tbl[6] = '{2, 2, 4, 0, 2, 0, 1};
    tbl[7] = '{0, 5, 13, 2, 2, 0, 3};
    tbl[8] = '{2, 2, 7, 1, 2, 0, 2};

    rst_n = 1'b0;
    start_s = 1'b0;
    abort_s = 1'b0;
    pix_en_s = 1'b0;
    h_s = '0;
    w_s = '0;
    pix_s = '0;
    sel = 0;
    #12;
    chk("rst_rstb", 32'(rstb_a[0]), 32'd1);
    chk("rst_enb", 32'(enb_a[0]), 32'd0);
    chk("rst_addr", addr_a[0], BASE);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    cyc();
    chk("rstb_rel", 32'(rstb_a[0]), 32'd0);
    chk("clkb_eq", 32'(clkb_a[0]), 32'(clk));

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i].s, tbl[i].hh, tbl[i].ww,
                tbl[i].gap, tbl[i].kind, tbl[i].extra);
      chk("n_writes", 32'(got_q.size()),
          32'(tbl[i].nwr));
      if (i == 0) begin
        chk("bits_din", got_at(0).din, 32'hAAAA_AAAA);
        chk("bits_addr", got_at(0).addr, BASE);
        chk("bits_web", 32'(got_at(0).web), 32'hF);
      end
      if (i == 1) begin
        chk("b8_din0", got_at(0).din, 32'h0102_0304);
        chk("b8_addr1", got_at(1).addr, BASE + 32'd4);
        chk("b8_din1", got_at(1).din, 32'h0506_0000);
        chk("b8_web1", 32'(got_at(1).web), 32'hC);
      end
      if (i == 8)
        chk("n4_web1", 32'(got_at(1).web), 32'hE);
    end

    // abort after 20 one-bit pixels, start held alongside
    sel = 0;
    exp_q.delete();
    got_q.delete();
    h_s = 11'd4;
    w_s = 11'd8;
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pix_s = 16'(i % 2);
      pix_en_s = 1'b1;
      cyc();
    end
    pix_en_s = 1'b0;
    d0 = done_cnt;
    abort_s = 1'b1;
    start_s = 1'b1;
    cyc();
    abort_s = 1'b0;
    start_s = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("abt_nowr", 32'(got_q.size()), 32'd0);
    chk("abt_busy", 32'(busy_a[0]), 32'd0);
    chk("abt_addr", addr_a[0], BASE);
    chk("abt_done", 32'(done_cnt - d0), 32'd0);
    run_frame(0, 4, 8, 0, 0, 0);
    chk("abt_re_addr", got_at(0).addr, BASE);
    chk("abt_re_din", got_at(0).din, 32'hAAAA_AAAA);

    // reset mid-word on the 8-bit packer
    sel = 1;
    exp_q.delete();
    got_q.delete();
    h_s = 11'd1;
    w_s = 11'd6;
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pix_s = 16'(i + 1);
      pix_en_s = 1'b1;
      cyc();
    end
    pix_en_s = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("ar_enb", 32'(enb_a[1]), 32'd0);
    chk("ar_web", 32'(web_a[1]), 32'd0);
    chk("ar_addr", addr_a[1], BASE);
    chk("ar_din", din_a[1], 32'd0);
    chk("ar_busy", 32'(busy_a[1]), 32'd0);
    chk("ar_done", 32'(done_a[1]), 32'd0);
    chk("ar_ovf", 32'(ovf_a[1]), 32'd0);
    chk("ar_rstb", 32'(rstb_a[1]), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 6; t++) cyc();
    chk("ar_nowr", 32'(got_q.size()), 32'd0);
    chk("ar_busy2", 32'(busy_a[1]), 32'd0);
    chk("ar_rstb2", 32'(rstb_a[1]), 32'd0);

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule
